// File: rtl/matmul_engine_pkg.sv
// Shared definitions for the matrix-multiply sequencer and its neighbours
// (memories and the UART transmit stage use the same address width).
package matmul_engine_pkg;

  localparam int ADDR_W_DEF = 6;

  // Encodings are visible on the LEDs through state_out, so keep them fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_MAC   = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/matmul_engine_mac.sv
// Multiply-accumulate datapath: one running dot product, plus a flag that
// tells the sequencer the sum no longer fits in a result element.
module mat_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              hi_nonzero
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;

  // clear wins over en so a WRITE cycle always leaves a fresh accumulator.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  assign hi_nonzero = |acc[ACC_W-1:DATA_W];

endmodule

// File: rtl/matmul_engine.sv
// Sequencer computing R = A x B for N x N unsigned matrices held in
// synchronous-read memories; results are written in row-major order.
module matmul_engine
  import matmul_engine_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              start,
  output logic              a_read,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              b_read,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              r_write,
  output logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_value,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [2:0]        state_out
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(N);

  state_t state, state_next;

  logic             start_q;
  logic [CNT_W-1:0] i, j, k;
  logic             last_i, last_j, last_k;
  logic             ovf_q;

  logic             mac_clear, mac_en;
  logic [ACC_W-1:0] acc;
  logic             hi_nonzero;

  logic [ADDR_W-1:0] addr_ik, addr_kj, addr_ij;

  assign last_i = (i == CNT_W'(N - 1));
  assign last_j = (j == CNT_W'(N - 1));
  assign last_k = (k == CNT_W'(N - 1));

  assign addr_ik = ADDR_W'(i) * ADDR_W'(N) + ADDR_W'(k);
  assign addr_kj = ADDR_W'(k) * ADDR_W'(N) + ADDR_W'(j);
  assign addr_ij = ADDR_W'(i) * ADDR_W'(N) + ADDR_W'(j);

  mat_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .slow_clk   (slow_clk),
    .rst        (rst),
    .clear      (mac_clear),
    .en         (mac_en),
    .a          (a_data),
    .b          (b_data),
    .acc        (acc),
    .hi_nonzero (hi_nonzero)
  );

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start;
    end
  end

  // k walks the dot product, j then i walk the result in row-major order.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      i     <= '0;
      j     <= '0;
      k     <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          i     <= '0;
          j     <= '0;
          k     <= '0;
          ovf_q <= 1'b0;
        end
        ST_MAC: begin
          if (!last_k) k <= k + 1'b1;
        end
        ST_WRITE: begin
          k <= '0;
          if (hi_nonzero) ovf_q <= 1'b1;
          if (!last_j) begin
            j <= j + 1'b1;
          end else if (!last_i) begin
            j <= '0;
            i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    a_read     = 1'b0;
    b_read     = 1'b0;
    a_addr     = '0;
    b_addr     = '0;
    r_write    = 1'b0;
    r_addr     = '0;
    r_value    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !start_q) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy       = 1'b1;
        mac_clear  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        busy       = 1'b1;
        a_read     = 1'b1;
        b_read     = 1'b1;
        a_addr     = addr_ik;
        b_addr     = addr_kj;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy       = 1'b1;
        state_next = ST_MAC;
      end
      ST_MAC: begin
        busy       = 1'b1;
        mac_en     = 1'b1;
        state_next = last_k ? ST_WRITE : ST_FETCH;
      end
      // The accumulator is cleared at the end of WRITE, after its low bits are stored.
      ST_WRITE: begin
        busy       = 1'b1;
        r_write    = 1'b1;
        r_addr     = addr_ij;
        r_value    = acc[DATA_W-1:0];
        mac_clear  = 1'b1;
        state_next = (last_i && last_j) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ovf       = ovf_q;
  assign state_out = state;

endmodule
